// File: rtl/wb_write_arbiter_pkg.sv
// Shared sizes and grant encodings for the write-back arbiter.
// Also carries the legacy register-file size defines used by neighbouring blocks.
`ifndef WB_WRITE_ARBITER_DEFINES
`define WB_WRITE_ARBITER_DEFINES
`define DataSize 32
`define RegAddrSize 5
`define DataBusReset 32'h0000_0000
`endif

package wb_write_arbiter_pkg;
   localparam int DATA_SIZE     = `DataSize;
   localparam int REG_ADDR_SIZE = `RegAddrSize;
   localparam logic WB_REQ_ALU  = 1'b0;
   localparam logic WB_REQ_LSU  = 1'b1;
endpackage

// File: rtl/wb_skid_fifo.sv
// Per-requester write-back FIFO holding {addr,data} entries.
// Exposes every entry's address and valid bit for the pending-write hazard compare.
module wb_skid_fifo
   import wb_write_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_SIZE,
   parameter int ADDR_W = REG_ADDR_SIZE,
   parameter int DEPTH  = 2
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         push,
   input  logic                         pop,
   input  logic [ADDR_W+DATA_W-1:0]     din,
   output logic [ADDR_W+DATA_W-1:0]     head,
   output logic                         headValid,
   output logic                         ready,
   output logic [DEPTH-1:0][ADDR_W-1:0] entryAddr,
   output logic [DEPTH-1:0]             entryValid
);
   localparam int ENTRY_W = ADDR_W + DATA_W;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;

   logic [ENTRY_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   count_r;
   logic [CNT_W-1:0]   count_next_s;
   logic [DEPTH-1:0]   valid_r;
   logic [DEPTH-1:0]   valid_next_s;
   logic               ready_r;
   logic               push_s;
   logic               pop_s;

   // Never write past full or read an empty slot, whatever the caller does.
   assign push_s = push & ready_r;
   assign pop_s  = pop & valid_r[rd_ptr_r];

   // Next occupancy and per-slot valid bits.
   always_comb begin
      count_next_s = count_r;
      valid_next_s = valid_r;
      if (push_s && !pop_s) begin
         count_next_s = count_r + CNT_W'(1);
      end else if (!push_s && pop_s) begin
         count_next_s = count_r - CNT_W'(1);
      end else begin
         count_next_s = count_r;
      end
      if (pop_s) begin
         valid_next_s[rd_ptr_r] = 1'b0;
      end else begin
         valid_next_s[rd_ptr_r] = valid_r[rd_ptr_r];
      end
      if (push_s) begin
         valid_next_s[wr_ptr_r] = 1'b1;
      end else begin
         valid_next_s[wr_ptr_r] = valid_next_s[wr_ptr_r];
      end
   end

   // Storage, pointers and the registered ready flag.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {ENTRY_W{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         valid_r  <= {DEPTH{1'b0}};
         ready_r  <= 1'b0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_next_s;
         valid_r <= valid_next_s;
         // Based on the next count, so a full FIFO drops ready even while popping.
         ready_r <= (count_next_s < CNT_W'(DEPTH));
      end
   end

   // Per-slot address view for the hazard compare.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         entryAddr[i] = mem_r[i][ENTRY_W-1 -: ADDR_W];
      end
   end

   assign head       = mem_r[rd_ptr_r];
   assign headValid  = valid_r[rd_ptr_r];
   assign ready      = ready_r;
   assign entryValid = valid_r;
endmodule

// File: rtl/wb_write_arbiter.sv
// Round-robin sharing of the register-file write port between ALU and LSU write-back.
// Optional macro WBARB_FWD_EN adds write-cycle forwarding outputs to the decoder.
module wb_write_arbiter
   import wb_write_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_SIZE,
   parameter int ADDR_W = REG_ADDR_SIZE,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              aluValid,
   output logic              aluReady,
   input  logic [ADDR_W-1:0] aluAddr,
   input  logic [DATA_W-1:0] aluData,
   input  logic              lsuValid,
   output logic              lsuReady,
   input  logic [ADDR_W-1:0] lsuAddr,
   input  logic [DATA_W-1:0] lsuData,
   output logic              wrEnOut,
   output logic [ADDR_W-1:0] wrAddrOut,
   output logic [DATA_W-1:0] wrDataOut,
   input  logic [ADDR_W-1:0] readAddrF,
   input  logic [ADDR_W-1:0] readAddrS,
   output logic              hazardF,
   output logic              hazardS,
`ifdef WBARB_FWD_EN
   output logic              fwdValidF,
   output logic              fwdValidS,
   output logic [DATA_W-1:0] fwdDataF,
   output logic [DATA_W-1:0] fwdDataS,
`endif
   output logic              busy
);
   localparam int ENTRY_W = ADDR_W + DATA_W;
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

   logic [ENTRY_W-1:0]         alu_head_s, lsu_head_s, win_head_s;
   logic                       alu_hv_s, lsu_hv_s;
   logic [DEPTH-1:0][ADDR_W-1:0] alu_eaddr_s, lsu_eaddr_s;
   logic [DEPTH-1:0]           alu_evld_s, lsu_evld_s;
   logic                       alu_push_s, lsu_push_s;
   logic                       grant_alu_s, grant_lsu_s;
   logic                       rr_r;
   logic                       wr_en_r;
   logic [ADDR_W-1:0]          wr_addr_r;
   logic [DATA_W-1:0]          wr_data_r;
   logic                       wr_hit_f_s, wr_hit_s_s;

   function automatic logic entry_hit(input logic [ADDR_W-1:0] a,
                                      input logic [DEPTH-1:0][ADDR_W-1:0] addrs,
                                      input logic [DEPTH-1:0] vld);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         hit = hit | (vld[i] & (addrs[i] == a));
      end
      return hit;
   endfunction

   // x0 writes complete the handshake but never occupy a slot.
   assign alu_push_s = aluValid & aluReady & (aluAddr != ADDR_ZERO);
   assign lsu_push_s = lsuValid & lsuReady & (lsuAddr != ADDR_ZERO);

   wb_skid_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_alu_fifo (
      .clk(clk), .resetN(resetN), .push(alu_push_s), .pop(grant_alu_s),
      .din({aluAddr, aluData}), .head(alu_head_s), .headValid(alu_hv_s),
      .ready(aluReady), .entryAddr(alu_eaddr_s), .entryValid(alu_evld_s)
   );

   wb_skid_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_lsu_fifo (
      .clk(clk), .resetN(resetN), .push(lsu_push_s), .pop(grant_lsu_s),
      .din({lsuAddr, lsuData}), .head(lsu_head_s), .headValid(lsu_hv_s),
      .ready(lsuReady), .entryAddr(lsu_eaddr_s), .entryValid(lsu_evld_s)
   );

   // Round-robin grant: on contention the requester not granted last time wins.
   always_comb begin
      grant_alu_s = 1'b0;
      grant_lsu_s = 1'b0;
      if (alu_hv_s && lsu_hv_s) begin
         if (rr_r == WB_REQ_LSU) begin
            grant_alu_s = 1'b1;
         end else begin
            grant_lsu_s = 1'b1;
         end
      end else if (alu_hv_s) begin
         grant_alu_s = 1'b1;
      end else if (lsu_hv_s) begin
         grant_lsu_s = 1'b1;
      end else begin
         grant_alu_s = 1'b0;
         grant_lsu_s = 1'b0;
      end
   end

   assign win_head_s = grant_lsu_s ? lsu_head_s : alu_head_s;

   // Last-grant pointer and the registered register-file write port.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rr_r      <= WB_REQ_LSU;
         wr_en_r   <= 1'b0;
         wr_addr_r <= {ADDR_W{1'b0}};
         wr_data_r <= {DATA_W{1'b0}};
      end else begin
         wr_en_r <= grant_alu_s | grant_lsu_s;
         if (grant_alu_s || grant_lsu_s) begin
            rr_r      <= grant_lsu_s ? WB_REQ_LSU : WB_REQ_ALU;
            wr_addr_r <= win_head_s[ENTRY_W-1 -: ADDR_W];
            wr_data_r <= win_head_s[DATA_W-1:0];
         end
      end
   end

   assign wr_hit_f_s = wr_en_r & (readAddrF == wr_addr_r);
   assign wr_hit_s_s = wr_en_r & (readAddrS == wr_addr_r);

   // Pending-write hazard; with forwarding the in-flight write is served instead.
   always_comb begin
      hazardF = 1'b0;
      hazardS = 1'b0;
      if (readAddrF != ADDR_ZERO) begin
         hazardF = entry_hit(readAddrF, alu_eaddr_s, alu_evld_s)
                 | entry_hit(readAddrF, lsu_eaddr_s, lsu_evld_s)
`ifndef WBARB_FWD_EN
                 | wr_hit_f_s
`endif
                 ;
      end else begin
         hazardF = 1'b0;
      end
      if (readAddrS != ADDR_ZERO) begin
         hazardS = entry_hit(readAddrS, alu_eaddr_s, alu_evld_s)
                 | entry_hit(readAddrS, lsu_eaddr_s, lsu_evld_s)
`ifndef WBARB_FWD_EN
                 | wr_hit_s_s
`endif
                 ;
      end else begin
         hazardS = 1'b0;
      end
   end

`ifdef WBARB_FWD_EN
   assign fwdValidF = wr_hit_f_s & (readAddrF != ADDR_ZERO);
   assign fwdValidS = wr_hit_s_s & (readAddrS != ADDR_ZERO);
   assign fwdDataF  = fwdValidF ? wr_data_r : {DATA_W{1'b0}};
   assign fwdDataS  = fwdValidS ? wr_data_r : {DATA_W{1'b0}};
`endif

   assign wrEnOut   = wr_en_r;
   assign wrAddrOut = wr_addr_r;
   assign wrDataOut = wr_data_r;
   assign busy      = (|alu_evld_s) | (|lsu_evld_s) | wr_en_r;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter (default build and WBARB_FWD_EN).
module tb_wb_write_arbiter;
   logic        clk = 1'b0;
   logic        resetN;
   logic        aluValid, lsuValid;
   logic        aluReady, lsuReady;
   logic [4:0]  aluAddr, lsuAddr, wrAddrOut, readAddrF, readAddrS;
   logic [31:0] aluData, lsuData, wrDataOut;
   logic        wrEnOut, hazardF, hazardS, busy;
`ifdef WBARB_FWD_EN
   logic        fwdValidF, fwdValidS;
   logic [31:0] fwdDataF, fwdDataS;
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [36:0] wr_log [$];

   wb_write_arbiter dut (
      .clk(clk), .resetN(resetN),
      .aluValid(aluValid), .aluReady(aluReady), .aluAddr(aluAddr), .aluData(aluData),
      .lsuValid(lsuValid), .lsuReady(lsuReady), .lsuAddr(lsuAddr), .lsuData(lsuData),
      .wrEnOut(wrEnOut), .wrAddrOut(wrAddrOut), .wrDataOut(wrDataOut),
      .readAddrF(readAddrF), .readAddrS(readAddrS),
      .hazardF(hazardF), .hazardS(hazardS),
`ifdef WBARB_FWD_EN
      .fwdValidF(fwdValidF), .fwdValidS(fwdValidS),
      .fwdDataF(fwdDataF), .fwdDataS(fwdDataS),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (resetN && wrEnOut) wr_log.push_back({wrAddrOut, wrDataOut});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      aluValid = 1'b0; lsuValid = 1'b0;
      aluAddr = 5'd0; lsuAddr = 5'd0; aluData = 32'd0; lsuData = 32'd0;
      readAddrF = 5'd0; readAddrS = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_wren", wrEnOut, 32'd0);
      check("rst_wraddr", wrAddrOut, 32'd0);
      check("rst_wrdata", wrDataOut, 32'd0);
      check("rst_busy", busy, 32'd0);
      check("rst_alurdy", aluReady, 32'd0);
      check("rst_lsurdy", lsuReady, 32'd0);
      @(negedge clk);
      resetN = 1'b1;
      step();
      check("rel_alurdy", aluReady, 32'd1);
      check("rel_lsurdy", lsuReady, 32'd1);
      wr_log.delete();
   endtask

   initial begin
      int ai, li, na, nl, w;
      logic a_rdy, l_rdy;
      logic [4:0] a;
      do_reset();

      // 1: single ALU write
      aluValid = 1'b1; aluAddr = 5'd5; aluData = 32'h0000_1234;
      step();
      aluValid = 1'b0;
      check("t1_no_early_write", wrEnOut, 32'd0);
      step();
      check("t1_wren", wrEnOut, 32'd1);
      check("t1_addr", wrAddrOut, 32'd5);
      check("t1_data", wrDataOut, 32'h0000_1234);
      check("t1_busy", busy, 32'd1);
      step();
      check("t1_wren_drop", wrEnOut, 32'd0);
      check("t1_addr_hold", wrAddrOut, 32'd5);
      check("t1_data_hold", wrDataOut, 32'h0000_1234);
      check("t1_idle", busy, 32'd0);

      // 2: contention, expect writes 1,3,2,4 back to back
      do_reset();
      aluValid = 1'b1; aluAddr = 5'd1; aluData = 32'hA000_0001;
      lsuValid = 1'b1; lsuAddr = 5'd3; lsuData = 32'hB000_0003;
      step();
      aluAddr = 5'd2; aluData = 32'hA000_0002;
      lsuAddr = 5'd4; lsuData = 32'hB000_0004;
      check("t2_no_early_write", wrEnOut, 32'd0);
      step();
      aluValid = 1'b0; lsuValid = 1'b0;
      check("t2_w0_en", wrEnOut, 32'd1);
      check("t2_w0_addr", wrAddrOut, 32'd1);
      check("t2_lsu_full", lsuReady, 32'd0);
      check("t2_alu_rdy", aluReady, 32'd1);
      step();
      check("t2_w1_en", wrEnOut, 32'd1);
      check("t2_w1_addr", wrAddrOut, 32'd3);
      check("t2_w1_data", wrDataOut, 32'hB000_0003);
      step();
      check("t2_w2_en", wrEnOut, 32'd1);
      check("t2_w2_addr", wrAddrOut, 32'd2);
      check("t2_w2_data", wrDataOut, 32'hA000_0002);
      step();
      check("t2_w3_en", wrEnOut, 32'd1);
      check("t2_w3_addr", wrAddrOut, 32'd4);
      check("t2_w3_data", wrDataOut, 32'hB000_0004);
      step();
      check("t2_done_en", wrEnOut, 32'd0);
      check("t2_done_busy", busy, 32'd0);
      check("t2_count", wr_log.size(), 32'd4);

      // 3: LSU FIFO fills, nothing lost or duplicated
      do_reset();
      ai = 0; li = 0;
      for (int cyc = 0; cyc < 40 && (ai < 4 || li < 4); cyc++) begin
         aluValid = (ai < 4); aluAddr = 5'(10 + ai); aluData = 32'hA000_0000 + 32'(10 + ai);
         lsuValid = (li < 4); lsuAddr = 5'(20 + li); lsuData = 32'hB000_0000 + 32'(20 + li);
         a_rdy = aluReady; l_rdy = lsuReady;
         step();
         if (aluValid && a_rdy) ai++;
         if (lsuValid && l_rdy) li++;
         if (cyc == 1) begin
            check("t3_lsu_accepts", li, 32'd2);
            check("t3_lsu_full", lsuReady, 32'd0);
         end
      end
      aluValid = 1'b0; lsuValid = 1'b0;
      check("t3_all_accepted", ai + li, 32'd8);
      for (w = 0; w < 20 && busy !== 1'b0; w++) step();
      check("t3_drain", busy, 32'd0);
      check("t3_count", wr_log.size(), 32'd8);
      na = 0; nl = 0;
      foreach (wr_log[i]) begin
         a = wr_log[i][36:32];
         if (a < 5'd20) begin
            check("t3_alu_order", a, 32'(10 + na));
            check("t3_alu_data", wr_log[i][31:0], 32'hA000_0000 + 32'(10 + na));
            na++;
         end else begin
            check("t3_lsu_order", a, 32'(20 + nl));
            check("t3_lsu_data", wr_log[i][31:0], 32'hB000_0000 + 32'(20 + nl));
            nl++;
         end
      end
      check("t3_alu_n", na, 32'd4);
      check("t3_lsu_n", nl, 32'd4);

      // 4: x0 request accepted but dropped
      wr_log.delete();
      aluValid = 1'b1; aluAddr = 5'd0; aluData = 32'h0000_FFFF;
      step();
      aluValid = 1'b0;
      check("t4_ready", aluReady, 32'd1);
      check("t4_busy0", busy, 32'd0);
      step();
      check("t4_wren", wrEnOut, 32'd0);
      check("t4_busy1", busy, 32'd0);
      step();
      check("t4_no_write", wr_log.size(), 32'd0);

      // 5: hazard on pending LSU writes
      do_reset();
      readAddrF = 5'd7; readAddrS = 5'd0;
      #1;
      check("t5_no_hazard", hazardF, 32'd0);
      lsuValid = 1'b1; lsuAddr = 5'd7; lsuData = 32'h0000_0077;
      step();
      lsuAddr = 5'd9; lsuData = 32'h0000_0099;
      check("t5_hazF_pend", hazardF, 32'd1);
      check("t5_hazS_zero", hazardS, 32'd0);
      step();
      lsuValid = 1'b0;
      readAddrS = 5'd9;
      #1;
      check("t5_w7_en", wrEnOut, 32'd1);
      check("t5_w7_addr", wrAddrOut, 32'd7);
      check("t5_hazF_wcyc", hazardF, 32'(!FWD));
      check("t5_hazS_entry", hazardS, 32'd1);
`ifdef WBARB_FWD_EN
      check("t5_fwdF_v", fwdValidF, 32'd1);
      check("t5_fwdF_d", fwdDataF, 32'h0000_0077);
      check("t5_fwdS_v", fwdValidS, 32'd0);
      check("t5_fwdS_d", fwdDataS, 32'd0);
`endif
      step();
      check("t5_w9_addr", wrAddrOut, 32'd9);
      check("t5_hazF_clear", hazardF, 32'd0);
      check("t5_hazS_wcyc", hazardS, 32'(!FWD));
`ifdef WBARB_FWD_EN
      check("t5_fwdS_v2", fwdValidS, 32'd1);
      check("t5_fwdS_d2", fwdDataS, 32'h0000_0099);
      check("t5_fwdF_v2", fwdValidF, 32'd0);
`endif
      step();
      check("t5_hazS_clear", hazardS, 32'd0);
      check("t5_idle", busy, 32'd0);

      // 6: reset while writes are pending
      do_reset();
      aluValid = 1'b1; aluAddr = 5'd10; aluData = 32'hA000_000A;
      lsuValid = 1'b1; lsuAddr = 5'd20; lsuData = 32'hB000_0014;
      step();
      aluAddr = 5'd11; lsuAddr = 5'd21;
      step();
      aluValid = 1'b0; lsuValid = 1'b0;
      readAddrF = 5'd21;
      #1;
      check("t6_wren_pre", wrEnOut, 32'd1);
      check("t6_hazF_pre", hazardF, 32'd1);
      resetN = 1'b0;
      #1;
      check("t6_wren_async", wrEnOut, 32'd0);
      check("t6_busy_async", busy, 32'd0);
      check("t6_hazF_async", hazardF, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetN = 1'b1;
      wr_log.delete();
      repeat (6) step();
      check("t6_no_writes", wr_log.size(), 32'd0);
      check("t6_busy", busy, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
